// File: rtl/npc_mem_pkg.sv
// Shared definitions for the NPC memory responders: FSM state encoding,
// default base address and byte-lane mask width.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;
  localparam int          MASK_W            = 4;

endpackage

// File: rtl/wmask_merge.sv
// Byte-lane merge: each enabled mask bit replaces the matching byte of the
// old word with the byte from the new word.
module wmask_merge
  import npc_mem_pkg::*;
(
  input  logic [31:0]       old_word,
  input  logic [31:0]       new_word,
  input  logic [MASK_W-1:0] mask,
  output logic [31:0]       merged
);

  // Per-lane select between stored and incoming byte
  always_comb begin
    merged = old_word;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Single-outstanding SRAM responder with fixed request-to-response latency,
// byte-lane writes and out-of-range error reporting.
module sram_responder
  import npc_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int          AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH  = 32'(DEPTH_WORDS);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic                enter_resp_s;
  logic                accept_s;

  logic                wen_r;
  logic [31:0]         addr_r;
  logic [31:0]         wdata_r;
  logic [MASK_W-1:0]   wmask_r;

  logic                acc_wen_s;
  logic [31:0]         acc_addr_s;
  logic [31:0]         acc_wdata_s;
  logic [MASK_W-1:0]   acc_wmask_s;
  logic [31:0]         offset_s;
  logic [31:0]         idx_s;
  logic [AW-1:0]       mem_idx_s;
  logic                in_range_s;
  logic [31:0]         old_word_s;
  logic [31:0]         merged_s;

  logic [31:0]         resp_rdata_r;
  logic                resp_err_r;

  logic [31:0]         mem_r [DEPTH_WORDS];

  assign accept_s   = req_valid && (state_r == IDLE);
  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == RESP);
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Next state and latency counter
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          cnt_nxt_s = LAT_M1;
          if (LATENCY == 1) begin
            state_nxt_s  = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_nxt_s = BUSY;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nxt_s  = RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request capture on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_r   <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wmask_r <= {MASK_W{1'b0}};
    end else if (accept_s) begin
      wen_r   <= req_wen;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      wmask_r <= req_wmask;
    end
  end

  // With LATENCY==1 the commit edge is the accept edge, so use live inputs
  always_comb begin
    if (state_r == IDLE) begin
      acc_wen_s   = req_wen;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      acc_wmask_s = req_wmask;
    end else begin
      acc_wen_s   = wen_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_wmask_s = wmask_r;
    end
  end

  assign offset_s   = acc_addr_s - BASE_ADDR;
  assign idx_s      = offset_s >> 2;
  assign mem_idx_s  = idx_s[AW-1:0];
  assign in_range_s = (acc_addr_s >= BASE_ADDR) && (idx_s < DEPTH);
  assign old_word_s = mem_r[mem_idx_s];

  wmask_merge u_merge (
    .old_word (old_word_s),
    .new_word (acc_wdata_s),
    .mask     (acc_wmask_s),
    .merged   (merged_s)
  );

  // Storage commit; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (!rst && enter_resp_s && in_range_s && acc_wen_s) begin
      mem_r[mem_idx_s] <= merged_s;
    end
  end

  // Response data/error, held stable throughout RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else if (enter_resp_s) begin
      resp_rdata_r <= (in_range_s && !acc_wen_s) ? old_word_s : 32'd0;
      resp_err_r   <= !in_range_s;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Randomized self-checking bench for sram_responder at LATENCY 2, 3 and 1,
// compared against a word-array reference model of a low memory window.
module tb_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NDUT = 3;
  localparam int          WIN  = 16;

  logic        clk;
  logic        rst        [NDUT];
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_wen    [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [3:0]  req_wmask  [NDUT];
  logic        resp_valid [NDUT];
  logic        resp_ready [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];

  logic [31:0] mdl [NDUT][WIN];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sram_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (1024),
      .LATENCY     ((g == 0) ? 2 : (g == 1) ? 3 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wen    (req_wen[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wmask  (req_wmask[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; checks timing, hold behaviour and data vs model
  task automatic do_txn(input int d, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int hold, output logic [31:0] got);
    int          lat;
    bit          inr;
    int          widx;
    logic [31:0] exp_rd;
    logic        exp_err;
    lat  = lat_of(d);
    inr  = (addr >= BASE) && (((addr - BASE) >> 2) < 32'd1024);
    widx = int'((addr - BASE) >> 2);
    exp_err = !inr;
    exp_rd  = (inr && !wen) ? mdl[d][widx] : 32'd0;
    got = 32'd0;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_wen[d]    = wen;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_wmask[d]  = wmask;
    resp_ready[d] = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid[d] = 1'($urandom);
        req_wen[d]   = 1'($urandom);
        req_addr[d]  = BASE + 32'($urandom_range(0, WIN - 1) * 4);
        req_wdata[d] = $urandom;
        req_wmask[d] = 4'($urandom);
      end
      chk("ready_busy", 32'(req_ready[d]), 32'd0);
      chk("valid_timing", 32'(resp_valid[d]), (k == lat) ? 32'd1 : 32'd0);
    end
    got = resp_rdata[d];
    chk("rdata", resp_rdata[d], exp_rd);
    chk("err", 32'(resp_err[d]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], exp_rd);
      chk("hold_err", 32'(resp_err[d]), 32'(exp_err));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("post_valid", 32'(resp_valid[d]), 32'd0);
    chk("post_ready", 32'(req_ready[d]), 32'd1);
    if (wen && inr) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mdl[d][widx][8*i +: 8] = wdata[8*i +: 8];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return 32'h7FFF_FFFC;
      1:       return BASE + 32'h0000_1000;
      2:       return $urandom & 32'h7FFF_FFFF;
      default: return BASE + 32'($urandom_range(0, WIN - 1) * 4) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic [31:0] got;
    logic [31:0] w0;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_wmask[d] = 4'd0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_rdata", resp_rdata[d], 32'd0);
      chk("rst_err", 32'(resp_err[d]), 32'd0);
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      rst[d] = 1'b0;
    end

    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < WIN; w++)
        do_txn(d, 1'b1, BASE + 32'(w * 4), $urandom, 4'hF, 0, got);

    do_txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, got);
    do_txn(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, got);
    chk("deadbeef", got, 32'hDEAD_BEEF);
    do_txn(0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, got);
    do_txn(0, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 1, got);
    do_txn(0, 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, got);
    chk("lane_merge", got, 32'h11BB_33DD);
    do_txn(0, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 0, got);
    do_txn(0, 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, got);
    chk("mask_zero", got, 32'h11BB_33DD);
    do_txn(0, 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 0, got);
    do_txn(0, 1'b0, BASE + 32'h0000_1000, 32'd0, 4'h0, 0, got);
    w0 = mdl[0][0];
    do_txn(0, 1'b1, BASE + 32'h0000_1000, ~w0, 4'hF, 0, got);
    do_txn(0, 1'b0, BASE, 32'd0, 4'h0, 0, got);
    chk("oor_write_nochange", got, w0);
    do_txn(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 5, got);

    w0 = mdl[1][0];
    @(negedge clk);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = BASE;
    req_wdata[1] = 32'h1234_5678; req_wmask[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("busy_rst_ready", 32'(req_ready[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("busy_rst_valid", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
    end
    do_txn(1, 1'b0, BASE, 32'd0, 4'h0, 0, got);
    chk("busy_rst_word", got, w0);

    @(negedge clk);
    req_valid[2] = 1'b1; req_wen[2] = 1'b0; req_addr[2] = 32'h8000_0010;
    resp_ready[2] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(resp_valid[2]), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("b2b_ready", 32'(req_ready[2]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 1) chk("b2b_rdata", resp_rdata[2], mdl[2][4]);
    end
    req_valid[2] = 1'b0;
    resp_ready[2] = 1'b0;

    for (int d = 0; d < NDUT; d++)
      for (int n = 0; n < 40; n++)
        do_txn(d, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
               $urandom_range(0, 3), got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
